// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single memory port between instruction fetch (IF) and load/store
//   (MEM). One requester is granted at a time. Its transaction is latched onto
//   the m_* port, and the arbiter waits for a variable-latency m_ready. The
//   result is then returned with a one-cycle done pulse. MEM normally wins a
//   contested grant. After MAX_MEM_STREAK contested MEM wins in a row, IF is
//   served, so IF cannot starve. An optional timeout aborts a transaction
//   that never completes.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr           fetch request level and address
//   if_rdata/if_done         fetched word and its one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata   load/store request
//   mem_rdata/mem_done       load data and its one-cycle completion pulse
//   m_req/m_we/m_addr/m_wdata           memory-side request (registered)
//   m_ready/m_rdata          memory completion and read data (same cycle)
//   err                      set together with a done pulse when that access timed out
//   stall_if/stall_mem       combinational stalls into the pipeline control
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_MEM_STREAK = 2,
  parameter int TIMEOUT        = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err,
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_MEM_STREAK);
  localparam logic [7:0] TO_LAST      = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [3:0]        streak_q, streak_d;
  logic [7:0]        busy_cnt_q, busy_cnt_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic              err_q, err_d;
  logic              grant_mem;

  // Streak counter saturates instead of wrapping so a long MEM burst can
  // never look like a fresh streak.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    sat_inc4 = (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      streak_q    <= '0;
      busy_cnt_q  <= '0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      busy_cnt_q  <= busy_cnt_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      err_q       <= err_d;
    end
  end

  // MEM wins unless IF is also waiting and MEM has already used up its streak.
  assign grant_mem = mem_req & (~if_req | (streak_q < STREAK_LIMIT));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    busy_cnt_d  = busy_cnt_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_mem) begin
          owner_d    = OWN_MEM;
          m_req_d    = 1'b1;
          m_we_d     = mem_we;
          m_addr_d   = mem_addr;
          m_wdata_d  = mem_wdata;
          busy_cnt_d = '0;
          streak_d   = if_req ? sat_inc4(streak_q) : 4'd0;
          state_d    = S_BUSY;
        end else if (if_req) begin
          owner_d    = OWN_IF;
          m_req_d    = 1'b1;
          m_we_d     = 1'b0;
          m_addr_d   = if_addr;
          m_wdata_d  = '0;
          busy_cnt_d = '0;
          streak_d   = 4'd0;
          state_d    = S_BUSY;
        end
      end

      S_BUSY: begin
        if (m_ready) begin
          m_req_d = 1'b0;
          state_d = S_DONE;
          if (owner_q == OWN_IF) begin
            if_rdata_d = m_rdata;
            if_done_d  = 1'b1;
          end else begin
            mem_rdata_d = m_rdata;
            mem_done_d  = 1'b1;
          end
        end else if ((TIMEOUT != 0) && (busy_cnt_q == TO_LAST)) begin
          // Abort: complete the access with zero data and flag it.
          m_req_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
          if (owner_q == OWN_IF) begin
            if_rdata_d = '0;
            if_done_d  = 1'b1;
          end else begin
            mem_rdata_d = '0;
            mem_done_d  = 1'b1;
          end
        end else begin
          busy_cnt_d = busy_cnt_q + 8'd1;
        end
      end

      // One dead cycle lets the finished requester drop or change its request
      // before it can be granted again.
      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  assign err       = err_q;

  // A requester is released only in the cycle its own result is presented.
  assign stall_if  = if_req  & ~((state_q == S_DONE) & (owner_q == OWN_IF));
  assign stall_mem = mem_req & ~((state_q == S_DONE) & (owner_q == OWN_MEM));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int MAXS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0, m_ready = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, m_rdata = '0;

  logic [31:0] if_rdata, mem_rdata, m_addr, m_wdata;
  logic        if_done, mem_done, m_req, m_we, err, stall_if, stall_mem;
  logic [31:0] if_rdata_t, mem_rdata_t, m_addr_t, m_wdata_t;
  logic        if_done_t, mem_done_t, m_req_t, m_we_t, err_t, stall_if_t, stall_mem_t;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_MEM_STREAK(MAXS), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .err(err),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  // Second instance with a short timeout, used for the abort scenario.
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_MEM_STREAK(MAXS), .TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_t), .if_done(if_done_t),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata_t), .mem_done(mem_done_t),
    .m_req(m_req_t), .m_we(m_we_t), .m_addr(m_addr_t), .m_wdata(m_wdata_t),
    .m_ready(m_ready), .m_rdata(m_rdata), .err(err_t),
    .stall_if(stall_if_t), .stall_mem(stall_mem_t)
  );

  task automatic do_reset();
    rst = 1'b1; if_req = 0; mem_req = 0; mem_we = 0; m_ready = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; m_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1; m_ready = 1'b1; m_rdata = 32'h1111_2222;
    @(negedge clk);
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL rst_m_req: got %0b want 0", m_req); end
    n_checks++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL rst_m_we: got %0b want 0", m_we); end
    n_checks++; if ({if_done, mem_done, err} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses: got %b want 000", {if_done, mem_done, err}); end
    n_checks++; if ({m_addr, m_wdata} !== 64'h0) begin n_fail++; $display("FAIL rst_m_bus: got %h want 0", {m_addr, m_wdata}); end
    n_checks++; if ({if_rdata, mem_rdata} !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", {if_rdata, mem_rdata}); end
    n_checks++; if ({stall_if, stall_mem} !== 2'b00) begin n_fail++; $display("FAIL rst_stalls: got %b want 00", {stall_if, stall_mem}); end
    m_ready = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_load();
    do_reset();
    mem_req = 1; mem_we = 0; mem_addr = 32'h100;
    #1;
    n_checks++; if (stall_mem !== 1'b1) begin n_fail++; $display("FAIL load_stall_c0: got %0b want 1", stall_mem); end
    @(negedge clk);
    n_checks++; if (m_req !== 1'b1 || m_addr !== 32'h100 || m_we !== 1'b0) begin n_fail++; $display("FAIL load_grant: got req=%0b addr=%h we=%0b want 1/100/0", m_req, m_addr, m_we); end
    n_checks++; if (mem_done !== 1'b0 || stall_mem !== 1'b1) begin n_fail++; $display("FAIL load_c1: got done=%0b stall=%0b want 0/1", mem_done, stall_mem); end
    m_ready = 1; m_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    m_ready = 0;
    n_checks++; if (mem_done !== 1'b1 || mem_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_done: got done=%0b data=%h want 1/deadbeef", mem_done, mem_rdata); end
    n_checks++; if (m_req !== 1'b0 || stall_mem !== 1'b0 || if_done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL load_c2: got req=%0b stall=%0b ifd=%0b err=%0b want 0000", m_req, stall_mem, if_done, err); end
    mem_req = 0;
    @(negedge clk);
    n_checks++; if (mem_done !== 1'b0 || m_req !== 1'b0) begin n_fail++; $display("FAIL load_c3: got done=%0b req=%0b want 0/0", mem_done, m_req); end
  endtask

  task automatic test_contention();
    int streak = 0;
    int if_cnt = 0;
    bit gm;
    logic [31:0] d;
    do_reset();
    if_req = 1; if_addr = 32'h400; mem_req = 1; mem_we = 0; mem_addr = 32'h800;
    for (int g = 0; g < 6; g++) begin
      gm = (streak < MAXS);
      streak = gm ? (streak == 15 ? 15 : streak + 1) : 0;
      @(negedge clk);
      n_checks++; if (m_req !== 1'b1 || m_addr !== (gm ? 32'h800 : 32'h400)) begin n_fail++; $display("FAIL cont_grant%0d: got req=%0b addr=%h want 1/%h", g, m_req, m_addr, gm ? 32'h800 : 32'h400); end
      @(negedge clk);
      d = $urandom; m_ready = 1; m_rdata = d;
      @(negedge clk);
      m_ready = 0;
      if (if_done === 1'b1) if_cnt++;
      n_checks++; if ({if_done, mem_done} !== (gm ? 2'b01 : 2'b10) || (gm ? mem_rdata : if_rdata) !== d) begin n_fail++; $display("FAIL cont_done%0d: got ifd/memd=%b want %b", g, {if_done, mem_done}, gm ? 2'b01 : 2'b10); end
      @(negedge clk);
    end
    n_checks++; if (if_cnt !== 2) begin n_fail++; $display("FAIL cont_if_served: got %0d want 2", if_cnt); end
  endtask

  task automatic test_store();
    do_reset();
    mem_req = 1; mem_we = 1; mem_addr = 32'h20; mem_wdata = 32'h1234_5678;
    @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      n_checks++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_wdata !== 32'h1234_5678 || m_addr !== 32'h20 || mem_done !== 1'b0) begin n_fail++; $display("FAIL store_busy%0d: got req=%0b we=%0b wd=%h a=%h done=%0b", k, m_req, m_we, m_wdata, m_addr, mem_done); end
      if (k < 5) @(negedge clk);
    end
    m_ready = 1; m_rdata = 32'hCAFE_0001;
    @(negedge clk);
    m_ready = 0;
    n_checks++; if (mem_done !== 1'b1 || mem_rdata !== 32'hCAFE_0001 || m_req !== 1'b0) begin n_fail++; $display("FAIL store_done: got done=%0b data=%h req=%0b want 1/cafe0001/0", mem_done, mem_rdata, m_req); end
    mem_req = 0;
    @(negedge clk);
    n_checks++; if (mem_done !== 1'b0) begin n_fail++; $display("FAIL store_pulse1: got %0b want 0", mem_done); end
    @(negedge clk);
    n_checks++; if (mem_done !== 1'b0 || m_req !== 1'b0) begin n_fail++; $display("FAIL store_pulse2: got done=%0b req=%0b want 0/0", mem_done, m_req); end
  endtask

  task automatic test_timeout();
    do_reset();
    if_req = 1; if_addr = 32'h40;
    @(negedge clk);
    m_ready = 1; m_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    m_ready = 0; if_req = 0;
    n_checks++; if (if_done_t !== 1'b1 || if_rdata_t !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL to_prefetch: got done=%0b data=%h want 1/a5a5a5a5", if_done_t, if_rdata_t); end
    @(negedge clk);
    if_req = 1; if_addr = 32'h44;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++; if (m_req_t !== 1'b1 || if_done_t !== 1'b0) begin n_fail++; $display("FAIL to_busy%0d: got req=%0b done=%0b want 1/0", k, m_req_t, if_done_t); end
    end
    @(negedge clk);
    n_checks++; if (if_done_t !== 1'b1 || err_t !== 1'b1) begin n_fail++; $display("FAIL to_abort: got done=%0b err=%0b want 1/1", if_done_t, err_t); end
    n_checks++; if (if_rdata_t !== 32'h0 || m_req_t !== 1'b0 || mem_done_t !== 1'b0) begin n_fail++; $display("FAIL to_abort_data: got data=%h req=%0b memd=%0b want 0/0/0", if_rdata_t, m_req_t, mem_done_t); end
    if_req = 0;
    @(negedge clk);
    m_ready = 1; m_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    m_ready = 0;
    n_checks++; if (if_done_t !== 1'b0 || err_t !== 1'b0 || m_req_t !== 1'b0 || if_rdata_t !== 32'h0) begin n_fail++; $display("FAIL to_late_ready: got done=%0b err=%0b req=%0b data=%h", if_done_t, err_t, m_req_t, if_rdata_t); end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    if_req = 1; if_addr = 32'h500;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (m_req !== 1'b0 || if_done !== 1'b0 || m_addr !== 32'h0) begin n_fail++; $display("FAIL rmb_async: got req=%0b done=%0b addr=%h want 0/0/0", m_req, if_done, m_addr); end
    n_checks++; if (stall_if !== 1'b1) begin n_fail++; $display("FAIL rmb_stall: got %0b want 1", stall_if); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (m_req !== 1'b1 || m_addr !== 32'h500 || m_we !== 1'b0) begin n_fail++; $display("FAIL rmb_regrant: got req=%0b addr=%h we=%0b want 1/500/0", m_req, m_addr, m_we); end
    m_ready = 1;
    @(negedge clk);
    m_ready = 0; if_req = 0;
    @(negedge clk);
    // Build a streak of 2 contested MEM grants, reset mid-access, then MEM
    // must again win twice (streak restarted from 0).
    if_req = 1; if_addr = 32'h600; mem_req = 1; mem_addr = 32'h700;
    @(negedge clk);
    m_ready = 1;
    @(negedge clk);
    m_ready = 0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (m_addr !== 32'h700) begin n_fail++; $display("FAIL rmb_mem2: got %h want 700", m_addr); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL rmb_async2: got %0b want 0", m_req); end
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      n_checks++; if (m_req !== 1'b1 || m_addr !== 32'h700) begin n_fail++; $display("FAIL rmb_streak%0d: got req=%0b addr=%h want 1/700", g, m_req, m_addr); end
      m_ready = 1;
      @(negedge clk);
      m_ready = 0;
      @(negedge clk);
    end
    if_req = 0; mem_req = 0;
  endtask

  task automatic test_drop_req();
    int pulses = 0;
    do_reset();
    mem_req = 1; mem_we = 0; mem_addr = 32'h300;
    @(negedge clk);
    mem_req = 0;
    #1;
    n_checks++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL drop_stall: got %0b want 0", stall_mem); end
    @(negedge clk);
    n_checks++; if (m_req !== 1'b1 || m_addr !== 32'h300) begin n_fail++; $display("FAIL drop_hold: got req=%0b addr=%h want 1/300", m_req, m_addr); end
    m_ready = 1; m_rdata = 32'h0BAD_F00D;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m_ready = 0;
      if (mem_done === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 1 || mem_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL drop_done: got pulses=%0d data=%h want 1/0badf00d", pulses, mem_rdata); end
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL drop_nogrant: got %0b want 0", m_req); end
  endtask

  task automatic test_random();
    int streak = 0;
    int d;
    bit pi = 0, pm = 0, gm, mwe = 0;
    logic [31:0] ia = '0, ma = '0, mw = '0, rd;
    logic [31:0] exp_addr, exp_wd;
    do_reset();
    for (int t = 0; t < 60; t++) begin
      if (!pi && $urandom_range(0, 1) != 0) begin pi = 1; ia = $urandom; end
      if (!pm && $urandom_range(0, 1) != 0) begin pm = 1; ma = $urandom; mw = $urandom; mwe = ($urandom_range(0, 1) == 1); end
      if_req = pi; if_addr = ia; mem_req = pm; mem_addr = ma; mem_we = mwe; mem_wdata = mw;
      if (!pi && !pm) begin
        @(negedge clk);
        n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL rnd_idle%0d: got req=%0b want 0", t, m_req); end
        continue;
      end
      gm = pm && (!pi || streak < MAXS);
      if (gm) streak = pi ? (streak == 15 ? 15 : streak + 1) : 0;
      else streak = 0;
      exp_addr = gm ? ma : ia;
      exp_wd   = gm ? mw : 32'h0;
      @(negedge clk);
      n_checks++; if (m_req !== 1'b1 || m_addr !== exp_addr || m_we !== (gm & mwe) || m_wdata !== exp_wd) begin n_fail++; $display("FAIL rnd_grant%0d: got req=%0b a=%h we=%0b wd=%h want a=%h wd=%h", t, m_req, m_addr, m_we, m_wdata, exp_addr, exp_wd); end
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        n_checks++; if (m_req !== 1'b1 || m_addr !== exp_addr || {if_done, mem_done} !== 2'b00 || {stall_if, stall_mem} !== {pi, pm}) begin n_fail++; $display("FAIL rnd_busy%0d: got req=%0b a=%h dn=%b st=%b", t, m_req, m_addr, {if_done, mem_done}, {stall_if, stall_mem}); end
      end
      rd = $urandom; m_ready = 1; m_rdata = rd;
      @(negedge clk);
      m_ready = 0;
      n_checks++; if ({if_done, mem_done} !== (gm ? 2'b01 : 2'b10) || (gm ? mem_rdata : if_rdata) !== rd || err !== 1'b0 || m_req !== 1'b0) begin n_fail++; $display("FAIL rnd_done%0d: got dn=%b err=%0b req=%0b want dn=%b data=%h", t, {if_done, mem_done}, err, m_req, gm ? 2'b01 : 2'b10, rd); end
      n_checks++; if ({stall_if, stall_mem} !== (gm ? {pi, 1'b0} : {1'b0, pm})) begin n_fail++; $display("FAIL rnd_stall%0d: got %b want %b", t, {stall_if, stall_mem}, gm ? {pi, 1'b0} : {1'b0, pm}); end
      if (gm) pm = 0; else pi = 0;
      if_req = pi; mem_req = pm;
      @(negedge clk);
      n_checks++; if ({if_done, mem_done, err} !== 3'b000) begin n_fail++; $display("FAIL rnd_pulse%0d: got %b want 000", t, {if_done, mem_done, err}); end
    end
    if_req = 0; mem_req = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_load();
    test_contention();
    test_store();
    test_timeout();
    test_reset_mid_busy();
    test_drop_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
